// File: rtl/rom_loader_if.sv
// rom_loader_if: stream-in / read-out bundle for rom_loader.
//   master (loader client):  drives start, wr_valid, wr_data, rd_addr
//   slave  (rom_loader):     drives wr_ready, rd_data, busy, done, csum
// Macro CHECKSUM_EN adds the csum signal.
interface rom_loader_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    logic                     start;
    logic                     wr_valid;
    logic [WIDTH-1:0]         wr_data;
    logic                     wr_ready;
    logic [$clog2(DEPTH)-1:0] rd_addr;
    logic [WIDTH-1:0]         rd_data;
    logic                     busy;
    logic                     done;
`ifdef CHECKSUM_EN
    logic [WIDTH-1:0]         csum;
`endif

    modport master (
        output start, wr_valid, wr_data, rd_addr,
        input  wr_ready, rd_data, busy, done
`ifdef CHECKSUM_EN
        , input csum
`endif
    );

    modport slave (
        input  start, wr_valid, wr_data, rd_addr,
        output wr_ready, rd_data, busy, done
`ifdef CHECKSUM_EN
        , output csum
`endif
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: boot-time loader for a lookup-table memory. After start, DEPTH words
// are taken from a valid/ready stream into mem[0..DEPTH-1]; the array is readable
// at all times through a 1-cycle registered port (read-before-write on collision).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         rom_loader_if.slave: start, wr_valid/wr_data/wr_ready, rd_addr/rd_data,
//               busy (LOAD), done (image complete, held until next start), csum
// Macro CHECKSUM_EN: adds an XOR checksum of accepted words on bus.csum.
module rom_loader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rom_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic             in_load, in_done, go, accept, last;

    assign last   = (wr_ptr == AW'(DEPTH - 1));
    assign accept = in_load && bus.wr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Status outputs decode from the state register only, so they are glitch-free.
    always_comb begin
        state_nxt = state;
        in_load   = 1'b0;
        in_done   = 1'b0;
        go        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    go        = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_load = 1'b1;
                if (bus.wr_valid && last) state_nxt = DONE;
            end
            DONE: begin
                in_done = 1'b1;
                if (bus.start) begin
                    go        = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wr_ready = in_load;
    assign bus.busy     = in_load;
    assign bus.done     = in_done;

    // Explicit wrap keeps wr_ptr inside the array for non-power-of-two DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wr_ptr <= '0;
        else if (go)     wr_ptr <= '0;
        else if (accept) wr_ptr <= last ? '0 : wr_ptr + 1'b1;
    end

    // Array itself is not reset; contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.wr_data;
    end

    // Non-blocking read of the pre-edge array gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       rd_q <= '0;
        else if (int'(bus.rd_addr) < DEPTH) rd_q <= mem[bus.rd_addr];
        else                              rd_q <= '0;
    end

    assign bus.rd_data = rd_q;

`ifdef CHECKSUM_EN
    logic [WIDTH-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      csum_q <= '0;
        else if (go)     csum_q <= '0;
        else if (accept) csum_q <= csum_q ^ bus.wr_data;
    end

    assign bus.csum = csum_q;
`else
    // No checksum state in this build.
`endif
endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    localparam int K_BUSY = 0;
    localparam int K_DONE = 1;
    localparam int K_WRDY = 2;
    localparam int K_RD   = 3;
    localparam int K_CSUM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_loader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

    rom_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t stq[$];
    chk_t rdq[$];
    chk_t c;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rd_req  = 1'b0;
    bit   rd_pend = 1'b0;

    function automatic logic [7:0] observe(int k);
        case (k)
            K_BUSY:  return {7'd0, bus.busy};
            K_DONE:  return {7'd0, bus.done};
            K_WRDY:  return {7'd0, bus.wr_ready};
            K_RD:    return bus.rd_data;
`ifdef CHECKSUM_EN
            K_CSUM:  return bus.csum;
`else
            K_CSUM:  return 8'd0;
`endif
            default: return 8'hxx;
        endcase
    endfunction

    task automatic compare(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read issued before an edge is checked at the following negedge;
    // status expectations are drained at the first negedge after they are queued.
    always @(posedge clk) rd_pend = rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rdq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %h expected none", bus.rd_data);
            end else begin
                c = rdq.pop_front();
                compare(c.name, bus.rd_data, c.exp);
            end
        end
        while (stq.size() > 0) begin
            c = stq.pop_front();
            compare(c.name, observe(c.kind), c.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(int k, logic [7:0] e, string n);
        stq.push_back('{k, e, n});
    endtask

    task automatic cyc(bit v, logic [7:0] d, bit r, logic [2:0] a, logic [7:0] e, string n);
        bus.wr_valid = v;
        bus.wr_data  = d;
        bus.rd_addr  = a;
        rd_req       = r;
        if (r) rdq.push_back('{K_RD, e, n});
        tick();
        bus.wr_valid = 1'b0;
        rd_req       = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Streams 8 words; with gaps, wr_valid is low every other cycle and a stray
    // start is raised during one gap (must be ignored in LOAD).
    task automatic load(logic [7:0] w[8], bit gaps, string n);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                exp_st(K_BUSY, 8'd1, {n, "_busy_gap"});
                if (i == 4) bus.start = 1'b1;
                cyc(1'b0, 8'hFF, 1'b0, 3'd0, 8'd0, n);
                bus.start = 1'b0;
            end
            exp_st(K_BUSY, 8'd1, {n, "_busy"});
            exp_st(K_WRDY, 8'd1, {n, "_wrdy"});
            exp_st(K_DONE, 8'd0, {n, "_done_early"});
            cyc(1'b1, w[i], 1'b0, 3'd0, 8'd0, n);
        end
        exp_st(K_BUSY, 8'd0, {n, "_busy_end"});
        exp_st(K_DONE, 8'd1, {n, "_done"});
        exp_st(K_WRDY, 8'd0, {n, "_wrdy_done"});
    endtask

    task automatic read_all(logic [7:0] w[8], string n);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'd0, 1'b1, 3'(i), w[i], n);
    endtask

    logic [7:0] w1[8];
    logic [7:0] w2[8];
    logic [7:0] w3[8];
    logic [7:0] w55[8];

    initial begin
        w1  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h12, 8'h34};
        w2  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        w3  = '{8'h01, 8'h02, 8'h99, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w55 = '{default: 8'h55};
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'd0;
        bus.rd_addr  = 3'd0;

        // Power-on reset
        tick();
        exp_st(K_BUSY, 8'd0, "rst_busy");
        exp_st(K_DONE, 8'd0, "rst_done");
        exp_st(K_WRDY, 8'd0, "rst_wrdy");
        exp_st(K_RD,   8'd0, "rst_rd");
        exp_st(K_CSUM, 8'd0, "rst_csum");
        tick();
        rst_n = 1'b1;
        tick();

        // Full back-to-back load, then read back
        do_start();
        load(w1, 1'b0, "full");
        read_all(w1, "full_rd");
        tick();

        // Reset asserted mid-cycle while DONE with nonzero rd_data
        #2;
        rst_n = 1'b0;
        exp_st(K_BUSY, 8'd0, "midrst_busy");
        exp_st(K_DONE, 8'd0, "midrst_done");
        exp_st(K_WRDY, 8'd0, "midrst_wrdy");
        exp_st(K_RD,   8'd0, "midrst_rd");
        exp_st(K_CSUM, 8'd0, "midrst_csum");
        tick();
        rst_n = 1'b1;

        // Words offered in IDLE are dropped
        exp_st(K_WRDY, 8'd0, "idle_wrdy");
        cyc(1'b1, 8'hEE, 1'b0, 3'd0, 8'd0, "idle_wr");
        cyc(1'b1, 8'hEF, 1'b0, 3'd0, 8'd0, "idle_wr");
        cyc(1'b0, 8'd0, 1'b1, 3'd0, 8'hA0, "idle_drop_rd0");
        cyc(1'b0, 8'd0, 1'b1, 3'd1, 8'hB1, "idle_drop_rd1");

        // Stalled stream
        do_start();
        load(w2, 1'b1, "stall");
        read_all(w2, "stall_rd");

        // Read-before-write on address 2 during a reload
        exp_st(K_WRDY, 8'd0, "done_wrdy");
        do_start();
        cyc(1'b1, w3[0], 1'b0, 3'd0, 8'd0, "rbw_w");
        cyc(1'b1, w3[1], 1'b0, 3'd0, 8'd0, "rbw_w");
        cyc(1'b1, w3[2], 1'b1, 3'd2, 8'h32, "rbw_old");
        cyc(1'b1, w3[3], 1'b1, 3'd2, 8'h99, "rbw_new");
        for (int i = 4; i < 8; i++) cyc(1'b1, w3[i], 1'b0, 3'd0, 8'd0, "rbw_w");
        exp_st(K_DONE, 8'd1, "rbw_done");

        // Start while DONE with a word on the bus: start wins, word dropped
        bus.start = 1'b1;
        cyc(1'b1, 8'hAB, 1'b0, 3'd0, 8'd0, "start_drop");
        bus.start = 1'b0;
        exp_st(K_BUSY, 8'd1, "start_drop_busy");
        cyc(1'b1, 8'h11, 1'b0, 3'd0, 8'd0, "part_w");
        cyc(1'b1, 8'h22, 1'b0, 3'd0, 8'd0, "part_w");
        cyc(1'b1, 8'h33, 1'b0, 3'd0, 8'd0, "part_w");

        // Reset mid-load after 3 accepts
        #2;
        rst_n = 1'b0;
        exp_st(K_BUSY, 8'd0, "ldrst_busy");
        exp_st(K_DONE, 8'd0, "ldrst_done");
        tick();
        rst_n = 1'b1;
        exp_st(K_DONE, 8'd0, "ldrst_done_after");
        cyc(1'b0, 8'd0, 1'b1, 3'd0, 8'h11, "ldrst_rd0");
        cyc(1'b0, 8'd0, 1'b1, 3'd1, 8'h22, "ldrst_rd1");
        cyc(1'b0, 8'd0, 1'b1, 3'd2, 8'h33, "ldrst_rd2");
        cyc(1'b0, 8'd0, 1'b1, 3'd3, 8'h04, "ldrst_rd3");
        do_start();
        load(w55, 1'b0, "reload");
        read_all(w55, "reload_rd");
        tick();

`ifdef CHECKSUM_EN
        do_start();
        load(w1, 1'b0, "csum");
        exp_st(K_CSUM, 8'h37, "csum_final");
        tick();
        exp_st(K_CSUM, 8'h37, "csum_hold");
        do_start();
        exp_st(K_CSUM, 8'h00, "csum_clr");
        exp_st(K_BUSY, 8'd1, "csum_restart_busy");
        tick();
`endif

        tick();
        if (stq.size() != 0 || rdq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", stq.size() + rdq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
